hamming_nibble_sequencer: RTL and testbench

- Controller between the CPU-side 32-bit data register and the Hamming(7,4) encoder datapath.
- Captures one 32-bit word through a valid/ready handshake.
- Issues the word to the encoder as NIBBLES consecutive 4-bit beats, each with its own valid/ready handshake.
- Flags the first and last beat and pulses done when the word has been fully consumed; supports a CPU soft abort.

---
 rtl/ham_seq_pkg.sv | 30 +++
 rtl/hamming_nibble_sequencer.sv | 149 ++++++++++++++
 tb/tb_hamming_nibble_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ham_seq_pkg.sv
// Shared types and helpers for the Hamming(7,4) nibble sequencer.
//   seq_state_t : FSM encoding (idle / send / done), 2 bits wide
//   NIBBLE_W    : beat width in bits
//   WORD_W      : CPU-side data word width
//   nibble_sel  : picks the 4-bit slice of a word for a given issue index
package ham_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } seq_state_t;

  // idx is the position in issue order; with msb_first the slice is mirrored
  // so that issue index 0 carries the most-significant active nibble.
  function automatic logic [NIBBLE_W-1:0] nibble_sel(input logic [WORD_W-1:0] word,
                                                     input int unsigned       idx,
                                                     input bit                msb_first,
                                                     input int unsigned       nibbles);
    int unsigned       pos;
    logic [WORD_W-1:0] shifted;
    pos     = msb_first ? (nibbles - 1 - idx) : idx;
    shifted = word >> (NIBBLE_W * pos);
    return shifted[NIBBLE_W-1:0];
  endfunction

endpackage

// File: rtl/hamming_nibble_sequencer.sv
// Sequencer between the CPU data register and the Hamming(7,4) encoder.
// Captures one 32-bit word on a valid/ready handshake, then issues NIBBLES
// 4-bit beats to the encoder, each with its own valid/ready handshake, and
// pulses done for one cycle once the last beat has been accepted.
//
// Parameters:
//   NIBBLES : beats per word (1..8); beats cover in_word[NIBBLES*4-1:0]
//   IDX_W   : beat index width, 2**IDX_W >= NIBBLES
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   abort      : synchronous soft clear, overrides every other event
//   in_valid   : CPU word available
//   in_word    : word to encode
//   in_ready   : sequencer can accept a word (idle)
//   out_valid  : out_nibble valid for the encoder
//   out_ready  : encoder accepts the current beat
//   out_nibble : current beat (0 outside SEND)
//   out_idx    : issue index of the current beat (0 outside SEND)
//   out_first  : current beat is index 0
//   out_last   : current beat is index NIBBLES-1
//   busy       : high in SEND and DONE
//   done       : one-cycle pulse after the last beat is accepted
//
// Build option:
//   HAM_SEQ_MSB_FIRST_EN : when defined, beats are issued most-significant
//                          nibble first; out_idx still counts 0..NIBBLES-1.
module hamming_nibble_sequencer
  import ham_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_word,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIBBLE_W-1:0] out_nibble,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_first,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

`ifdef HAM_SEQ_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NIBBLES - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (abort) begin
      // A beat shown this cycle with out_ready high is already consumed by the
      // encoder; we simply stop issuing and skip the done pulse.
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // in_ready is constantly high in idle, so in_valid alone completes the handshake
          if (in_valid) begin
            word_d  = in_word;
            idx_d   = '0;
            state_d = StSend;
          end
        end
        StSend: begin
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              state_d = StDone;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          idx_d   = '0;
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output logic, decoded from state only so outputs stay stable while stalled
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_nibble = '0;
    out_idx    = '0;
    out_first  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
      end
      StSend: begin
        out_valid  = 1'b1;
        out_nibble = nibble_sel(word_q, 32'(idx_q), MsbFirst, NIBBLES);
        out_idx    = idx_q;
        out_first  = (idx_q == '0);
        out_last   = (idx_q == LastIdx);
        busy       = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hamming_nibble_sequencer.sv
// Self-checking bench for hamming_nibble_sequencer: an 8-beat instance for the
// main scenarios and a 1-beat instance for the single-nibble corner case.
module tb_hamming_nibble_sequencer;

`ifdef HAM_SEQ_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  localparam int NIB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-beat instance
  logic        abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, out_valid, out_first, out_last, busy, done;
  logic [3:0]  out_nibble;
  logic [2:0]  out_idx;

  // 1-beat instance
  logic        b_abort = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_in_word = '0;
  logic        b_in_ready, b_out_valid, b_out_first, b_out_last, b_busy, b_done;
  logic [3:0]  b_out_nibble;
  logic [0:0]  b_out_idx;

  hamming_nibble_sequencer #(.NIBBLES(8), .IDX_W(3)) u_dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_nibble(out_nibble), .out_idx(out_idx), .out_first(out_first),
    .out_last(out_last), .busy(busy), .done(done)
  );

  hamming_nibble_sequencer #(.NIBBLES(1), .IDX_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .abort(b_abort), .in_valid(b_in_valid), .in_word(b_in_word),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_nibble(b_out_nibble), .out_idx(b_out_idx), .out_first(b_out_first),
    .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic [3:0] nib;
    logic [2:0] idx;
    logic       first;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [3:0] exp_nib(input logic [31:0] w, input int k, input int n);
    int          pos;
    logic [31:0] s;
    pos = MsbFirst ? (n - 1 - k) : k;
    s   = w >> (4 * pos);
    return s[3:0];
  endfunction

  task automatic push_word(input logic [31:0] w);
    beat_t b;
    for (int k = 0; k < NIB; k++) begin
      b.nib   = exp_nib(w, k, NIB);
      b.idx   = 3'(k);
      b.first = (k == 0);
      b.last  = (k == NIB - 1);
      sb.push_back(b);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_word(input string name, input logic [31:0] w, input bit toggle);
    beat_t got;
    bit    seen_done = 1'b0;
    push_word(w);
    in_valid  = 1'b1;
    in_word   = w;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_before_capture: got %b want 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = ~w;  // must not affect the captured word
    for (int k = 0; k < 64; k++) begin
      out_ready = toggle ? ((k % 2) == 0) : 1'b1;
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
          miscompares++;
          $display("FAIL %s done_cycle: out_valid=%b pending=%0d want 0/0",
                   name, out_valid, sb.size());
        end
        if (!toggle) begin
          vectors++;
          if (k != NIB) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d want %0d cycles after first beat",
                     name, k, NIB);
          end
        end
        break;
      end
      if (out_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_beat: got nib=%h idx=%0d want none", name, out_nibble, out_idx);
        end else begin
          got = {out_nibble, out_idx, out_first, out_last};
          if (got !== sb[0]) begin
            miscompares++;
            $display("FAIL %s beat: got nib=%h idx=%0d f=%b l=%b want nib=%h idx=%0d f=%b l=%b",
                     name, got.nib, got.idx, got.first, got.last,
                     sb[0].nib, sb[0].idx, sb[0].first, sb[0].last);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL %s out_valid_dropped: got 0 want 1 at cycle %0d", name, k);
      end
      @(posedge clk);
      #1;
    end
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s done_timeout: got no done want done", name);
    end
    sb.delete();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({in_ready, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s back_to_idle: got rdy/busy/done=%b want 100", name, {in_ready, busy, done});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vectors++;
    if ({in_ready, out_valid, out_nibble, out_idx, out_first, out_last, busy, done}
        !== {1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b v=%b nib=%h idx=%0d f=%b l=%b busy=%b done=%b want 1 0 0 0 0 0 0 0",
               in_ready, out_valid, out_nibble, out_idx, out_first, out_last, busy, done);
    end
    vectors++;
    if ({b_in_ready, b_out_valid, b_busy, b_done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_outputs_n1: got %b want 1000", {b_in_ready, b_out_valid, b_busy, b_done});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    run_word("stream", 32'h8765_4321, 1'b0);
  endtask

  task automatic test_stall();
    run_word("stall", 32'hDEAD_BEEF, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_word("b2b_a", 32'hA5C3_0F96, 1'b0);
    run_word("b2b_b", 32'h0123_4567, 1'b1);
  endtask

  task automatic test_abort();
    logic [31:0] w = 32'hFFFF_0000;
    bit found = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd3) begin
        found = 1'b1;
        vectors++;
        if (out_nibble !== exp_nib(w, 3, NIB)) begin
          miscompares++;
          $display("FAIL abort_beat3: got %h want %h", out_nibble, exp_nib(w, 3, NIB));
        end
        abort = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL abort_reach_idx3: got never want idx 3");
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_idle: got rdy/v/busy/done=%b want 1000", {in_ready, out_valid, busy, done});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %b want 0", done);
    end
    // abort together with in_valid in idle must not capture
    in_valid = 1'b1;
    abort    = 1'b1;
    in_word  = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL abort_blocks_capture: got rdy/busy/v=%b want 100", {in_ready, busy, out_valid});
    end
    @(posedge clk);
    #1;
    run_word("after_abort", 32'h0000_000A, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rstmid_reach_idx5: got never want idx 5");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_nibble, out_idx, out_first, out_last, busy, done}
        !== {1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got rdy=%b v=%b nib=%h idx=%0d f=%b l=%b busy=%b done=%b want 1 0 0 0 0 0 0 0",
               in_ready, out_valid, out_nibble, out_idx, out_first, out_last, busy, done);
    end
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({in_ready, busy, out_valid, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL rstmid_idle_after: got rdy/busy/v/done=%b want 1000", {in_ready, busy, out_valid, done});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_nibble();
    b_in_valid  = 1'b1;
    b_in_word   = 32'h0000_0007;
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_word  = 32'hFFFF_FFFF;
    @(negedge clk);
    vectors++;
    if ({b_out_valid, b_out_nibble, b_out_first, b_out_last, b_out_idx} !== {1'b1, 4'h7, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL n1_beat: got v=%b nib=%h f=%b l=%b idx=%0d want 1 7 1 1 0",
               b_out_valid, b_out_nibble, b_out_first, b_out_last, b_out_idx);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({b_done, b_out_valid, b_in_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL n1_done: got done/v/rdy=%b want 100", {b_done, b_out_valid, b_in_ready});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({b_done, b_in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL n1_idle: got done/rdy=%b want 01", {b_done, b_in_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_msb_order();
    run_word("order", 32'h1234_5678, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_abort();
    test_reset_mid();
    test_single_nibble();
    test_msb_order();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
